// File: rtl/drum_audio_sink_if.sv
// Sample stream from the drum solver plus the Avalon-MM master port to the audio codec.
// The master modport is the sink's view; slave is the solver/codec side.
interface drum_audio_sink_if;
  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned BUS_W    = 32;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic [BUS_W-1:0]    bus_address;
  logic                bus_read;
  logic                bus_write;
  logic [BUS_W-1:0]    bus_writedata;
  logic [BUS_W-1:0]    bus_readdata;
  logic                bus_waitrequest;

  modport master (
    input  sample_in, sample_valid, bus_readdata, bus_waitrequest,
    output sample_ready, bus_address, bus_read, bus_write, bus_writedata
  );

  modport slave (
    output sample_in, sample_valid, bus_readdata, bus_waitrequest,
    input  sample_ready, bus_address, bus_read, bus_write, bus_writedata
  );
endinterface

// File: rtl/drum_audio_sink.sv
// Buffers solver center-node samples in a FIFO and drains them to the audio codec:
// poll FIFOSPACE, then write the same left-justified word to LEFTDATA and RIGHTDATA.
module drum_audio_sink #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] AUDIO_BASE  = 32'h0000_3040,
  parameter int unsigned ATTEN_SHIFT = 0
) (
  input  logic               clk_50,
  input  logic               reset,
  drum_audio_sink_if.master  bus,
  output logic [5:0]         fifo_count,
  output logic [31:0]        samples_sent
);
  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned BUS_W    = 32;
  localparam int unsigned PAD_W    = BUS_W - SAMPLE_W;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned SLOT_W   = 8;

  localparam logic [BUS_W-1:0] ADDR_SPACE = AUDIO_BASE + 32'd4;
  localparam logic [BUS_W-1:0] ADDR_LEFT  = AUDIO_BASE + 32'd8;
  localparam logic [BUS_W-1:0] ADDR_RIGHT = AUDIO_BASE + 32'd12;

  typedef enum logic [2:0] {IDLE, RD_SPACE, CHK, WR_L, WR_R} state_t;

  state_t state, state_next;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                ready_q;
  logic [SLOT_W-1:0]   wsrc, wslc;
  logic [BUS_W-1:0]    addr_q, wdata_q, sent_q;
  logic                read_q, write_q;

  logic [SLOT_W-1:0]   wsrc_d, wslc_d;
  logic [BUS_W-1:0]    addr_d, wdata_d, sent_d;
  logic                read_d, write_d;

  logic                push_c, pop_c;
  logic [CNT_W-1:0]    count_next_c;
  logic signed [SAMPLE_W-1:0] head_c, shifted_c;
  logic [BUS_W-1:0]    packed_c;

  assign push_c       = bus.sample_valid && ready_q;
  assign count_next_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

  // Attenuate with sign preserved, then left-justify 1.17 into the codec's 32-bit word.
  assign head_c    = mem[rd_ptr];
  assign shifted_c = head_c >>> ATTEN_SHIFT;
  assign packed_c  = {shifted_c, {PAD_W{1'b0}}};

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      wsrc    <= '0;
      wslc    <= '0;
      addr_q  <= AUDIO_BASE;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      sent_q  <= '0;
    end else begin
      state   <= state_next;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next_c;
      ready_q <= (count_next_c < CNT_W'(FIFO_DEPTH));
      wsrc    <= wsrc_d;
      wslc    <= wslc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      sent_q  <= sent_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_50) begin
    if (push_c) mem[wr_ptr] <= bus.sample_in;
  end

  always_comb begin
    state_next = state;
    wsrc_d     = wsrc;
    wslc_d     = wslc;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    read_d     = read_q;
    write_d    = write_q;
    sent_d     = sent_q;
    pop_c      = 1'b0;

    unique case (state)
      IDLE: begin
        if (count_q != '0) begin
          addr_d     = ADDR_SPACE;
          read_d     = 1'b1;
          state_next = RD_SPACE;
        end
      end
      RD_SPACE: begin
        if (!bus.bus_waitrequest) begin
          wsrc_d     = bus.bus_readdata[23:16];
          wslc_d     = bus.bus_readdata[31:24];
          read_d     = 1'b0;
          state_next = CHK;
        end
      end
      CHK: begin
        // No room in either codec channel: go back and poll again, sample stays queued.
        if (wsrc != '0 && wslc != '0) begin
          pop_c      = 1'b1;
          addr_d     = ADDR_LEFT;
          wdata_d    = packed_c;
          write_d    = 1'b1;
          state_next = WR_L;
        end else begin
          state_next = IDLE;
        end
      end
      WR_L: begin
        if (!bus.bus_waitrequest) begin
          addr_d     = ADDR_RIGHT;
          state_next = WR_R;
        end
      end
      WR_R: begin
        if (!bus.bus_waitrequest) begin
          write_d    = 1'b0;
          sent_d     = sent_q + 32'd1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sample_ready  = ready_q;
  assign bus.bus_address   = addr_q;
  assign bus.bus_read      = read_q;
  assign bus.bus_write     = write_q;
  assign bus.bus_writedata = wdata_q;
  assign fifo_count        = count_q;
  assign samples_sent      = sent_q;
endmodule

// File: tb/tb_drum_audio_sink.sv
// Bench for drum_audio_sink: two instances (no attenuation and >>>2) driven identically,
// checked each cycle against a sample-queue model of the FIFO and the expected codec writes.
module tb_drum_audio_sink;
  localparam int unsigned DEPTH   = 8;
  localparam logic [31:0] BASE    = 32'h0000_3040;
  localparam logic [31:0] A_SPACE = BASE + 32'd4;
  localparam logic [31:0] A_LEFT  = BASE + 32'd8;
  localparam logic [31:0] A_RIGHT = BASE + 32'd12;

  typedef struct packed {
    logic        ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  cnt;
    logic [31:0] sent;
  } obs_t;

  typedef struct {
    logic [17:0] sample;
    logic [31:0] word0;
    logic [31:0] word2;
  } vec_t;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  always #10 clk_50 = ~clk_50;

  drum_audio_sink_if bus0 ();
  drum_audio_sink_if bus2 ();
  logic [5:0]  count0, count2;
  logic [31:0] sent0, sent2;

  drum_audio_sink #(.FIFO_DEPTH(DEPTH), .AUDIO_BASE(BASE), .ATTEN_SHIFT(0)) dut0 (
    .clk_50(clk_50), .reset(reset), .bus(bus0), .fifo_count(count0), .samples_sent(sent0));
  drum_audio_sink #(.FIFO_DEPTH(DEPTH), .AUDIO_BASE(BASE), .ATTEN_SHIFT(2)) dut2 (
    .clk_50(clk_50), .reset(reset), .bus(bus2), .fifo_count(count2), .samples_sent(sent2));

  int errors = 0;
  int checks = 0;
  int tick_no = 0;

  obs_t        p0, p2;
  logic        p_valid = 1'b0;
  logic        p_wait  = 1'b0;
  logic        p_reset = 1'b1;
  logic [17:0] p_sample = '0;

  logic [17:0] src_q[$];
  logic [17:0] mq[$];
  logic [31:0] e0_addr[$], e0_data[$], e2_addr[$], e2_data[$];
  logic [31:0] last_l0, last_r0, last_l2, last_r2;
  logic [31:0] space_word = 32'h8080_0000;
  int m_sent = 0, polls = 0, accepted = 0;
  int t_accept = 0, t_lstart = 0, t_rdone = 0;
  int stall_left = 0;
  bit wait_rand = 1'b0, space_rand = 1'b0, rst_req = 1'b1, rst_on_r = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Codec word: signed value shifted down, then scaled by 2^14 into 32 bits.
  function automatic logic [31:0] pack(input logic [17:0] s, input int sh);
    int v;
    v = $signed(s);
    v = v >>> sh;
    return 32'(v) << 14;
  endfunction

  task automatic cmp_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ea, ed;
    if (idx == 0) begin
      chk("wr0_pending", 64'(e0_addr.size() > 0), 64'(1));
      if (e0_addr.size() > 0) begin
        ea = e0_addr.pop_front();
        ed = e0_data.pop_front();
        chk("wr0_addr", 64'(a), 64'(ea));
        chk("wr0_data", 64'(d), 64'(ed));
      end
      if (a == A_LEFT) last_l0 = d;
      else if (a == A_RIGHT) last_r0 = d;
    end else begin
      chk("wr2_pending", 64'(e2_addr.size() > 0), 64'(1));
      if (e2_addr.size() > 0) begin
        ea = e2_addr.pop_front();
        ed = e2_data.pop_front();
        chk("wr2_addr", 64'(a), 64'(ea));
        chk("wr2_data", 64'(d), 64'(ed));
      end
      if (a == A_LEFT) last_l2 = d;
      else if (a == A_RIGHT) last_r2 = d;
    end
  endtask

  task automatic drive_inputs(input logic [31:0] rd);
    reset = p_reset;
    bus0.sample_valid = p_valid;  bus2.sample_valid = p_valid;
    bus0.sample_in = p_sample;    bus2.sample_in = p_sample;
    bus0.bus_waitrequest = p_wait; bus2.bus_waitrequest = p_wait;
    bus0.bus_readdata = rd;       bus2.bus_readdata = rd;
  endtask

  // One clock: observe after the edge, update the model, then drive the next inputs.
  task automatic tick();
    obs_t c0, c2;
    bit acc;
    logic [17:0] s;
    logic [31:0] rd;
    @(negedge clk_50);
    tick_no++;
    c0 = '{bus0.sample_ready, bus0.bus_read, bus0.bus_write, bus0.bus_address,
           bus0.bus_writedata, count0, sent0};
    c2 = '{bus2.sample_ready, bus2.bus_read, bus2.bus_write, bus2.bus_address,
           bus2.bus_writedata, count2, sent2};
    acc = 1'b0;
    if (p_reset) begin
      mq.delete(); e0_addr.delete(); e0_data.delete(); e2_addr.delete(); e2_data.delete();
      m_sent = 0;
      chk("rst_ready", 64'(c0.ready), 64'(0));
      chk("rst_strobes", 64'({c0.rd, c0.wr, c2.rd, c2.wr}), 64'(0));
      chk("rst_addr", 64'(c0.addr), 64'(BASE));
      chk("rst_wdata", 64'(c0.wdata), 64'(0));
      chk("rst_count", 64'({c0.cnt, c2.cnt}), 64'(0));
      chk("rst_sent", 64'(c0.sent), 64'(0));
    end else begin
      if (p_valid && p0.ready) begin
        mq.push_back(p_sample);
        acc = 1'b1;
        accepted++;
        t_accept = tick_no;
      end
      if (p0.rd && !p_wait) polls++;
      if (p0.wr && !p_wait) begin
        cmp_write(0, p0.addr, p0.wdata);
        if (p0.addr == A_RIGHT) begin
          m_sent++;
          t_rdone = tick_no;
        end
      end
      if (p2.wr && !p_wait) cmp_write(1, p2.addr, p2.wdata);
      if (c0.wr && c0.addr == A_LEFT && !(p0.wr && p0.addr == A_LEFT)) begin
        t_lstart = tick_no;
        chk("pop_nonempty", 64'(mq.size() > 0), 64'(1));
        if (mq.size() > 0) begin
          s = mq.pop_front();
          e0_addr.push_back(A_LEFT);  e0_data.push_back(pack(s, 0));
          e0_addr.push_back(A_RIGHT); e0_data.push_back(pack(s, 0));
          e2_addr.push_back(A_LEFT);  e2_data.push_back(pack(s, 2));
          e2_addr.push_back(A_RIGHT); e2_data.push_back(pack(s, 2));
        end
      end
      chk("count", 64'(c0.cnt), 64'(mq.size()));
      chk("count_atten", 64'(c2.cnt), 64'(mq.size()));
      chk("ready", 64'(c0.ready), 64'(mq.size() < DEPTH));
      chk("sent", 64'(c0.sent), 64'(m_sent));
      chk("rd_wr_excl", 64'({c0.rd & c0.wr, c2.rd & c2.wr}), 64'(0));
      if (c0.rd) chk("read_addr", 64'(c0.addr), 64'(A_SPACE));
      if ((p0.rd || p0.wr) && p_wait) begin
        chk("hold_addr", 64'(c0.addr), 64'(p0.addr));
        chk("hold_ctl", 64'({c0.rd, c0.wr, c0.wdata}), 64'({p0.rd, p0.wr, p0.wdata}));
      end
    end

    if (acc) void'(src_q.pop_front());
    p_valid  = src_q.size() > 0;
    p_sample = p_valid ? src_q[0] : 18'($urandom);
    p_wait   = wait_rand && ($urandom_range(0, 2) == 0);
    if (stall_left > 0 && c0.wr && c0.addr == A_LEFT) begin
      p_wait = 1'b1;
      stall_left--;
    end
    rd = space_rand ? {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 16'($urandom)}
                    : space_word;
    p_reset = rst_req || (rst_on_r && c0.wr && c0.addr == A_RIGHT);
    if (p_reset) rst_on_r = 1'b0;
    drive_inputs(rd);
    p0 = c0;
    p2 = c2;
  endtask

  initial begin
    vec_t vecs [6];
    int start, start_polls, acc0;
    logic [31:0] hold_data;

    vecs[0] = '{18'h10000, 32'h4000_0000, 32'h1000_0000};
    vecs[1] = '{18'h20000, 32'h8000_0000, 32'hE000_0000};
    vecs[2] = '{18'h1FFFF, 32'h7FFF_C000, 32'h1FFF_C000};
    vecs[3] = '{18'h3FFFF, 32'hFFFF_C000, 32'hFFFF_C000};
    vecs[4] = '{18'h00001, 32'h0000_4000, 32'h0000_0000};
    vecs[5] = '{18'h2AAAA, 32'hAAAA_8000, 32'hEAAA_8000};

    p0 = '0;
    p2 = '0;
    drive_inputs(space_word);

    // Reset, then ten idle cycles with no offered samples.
    tick();
    rst_req = 1'b0;
    tick();
    tick();
    chk("ready_after_reset", 64'(p0.ready), 64'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_strobe", 64'({p0.rd, p0.wr, p2.rd, p2.wr}), 64'(0));
    end

    // Single samples through a zero-wait slave with space available.
    for (int i = 0; i < 6; i++) begin
      start = m_sent;
      src_q.push_back(vecs[i].sample);
      for (int n = 0; n < 40 && m_sent == start; n++) tick();
      chk("pair_done", 64'(m_sent), 64'(start + 1));
      chk("latency_left", 64'(t_lstart - t_accept), 64'(3));
      chk("pair_cycles", 64'(t_rdone - t_accept), 64'(5));
      chk("left0", 64'(last_l0), 64'(vecs[i].word0));
      chk("right0", 64'(last_r0), 64'(vecs[i].word0));
      chk("left_atten", 64'(last_l2), 64'(vecs[i].word2));
      chk("right_atten", 64'(last_r2), 64'(vecs[i].word2));
    end

    // Codec reports no space: FIFO fills, source is back-pressured, then everything drains in order.
    space_word  = 32'h0000_0000;
    start       = m_sent;
    start_polls = polls;
    acc0        = accepted;
    for (int i = 0; i < 10; i++) src_q.push_back(18'(i * 9103 + 77));
    for (int n = 0; n < 400 && polls < start_polls + 20; n++) tick();
    chk("polls_reached", 64'(polls >= start_polls + 20), 64'(1));
    chk("full_count", 64'(p0.cnt), 64'(DEPTH));
    chk("full_ready", 64'(p0.ready), 64'(0));
    chk("held_by_source", 64'(src_q.size()), 64'(2));
    chk("accepted_8", 64'(accepted - acc0), 64'(8));
    space_word = 32'h0101_0000;
    for (int n = 0; n < 300 && m_sent < start + 10; n++) tick();
    chk("drained_10", 64'(m_sent - start), 64'(10));
    chk("none_left", 64'(mq.size() + src_q.size()), 64'(0));

    // Four wait states on the LEFTDATA write.
    space_word = 32'h8080_0000;
    stall_left = 4;
    start      = m_sent;
    src_q.push_back(18'h05A5A);
    for (int n = 0; n < 30 && !(p0.wr && p0.addr == A_LEFT); n++) tick();
    chk("stall_left_seen", 64'(p0.wr && p0.addr == A_LEFT), 64'(1));
    hold_data = p0.wdata;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_addr", 64'(p0.addr), 64'(A_LEFT));
      chk("stall_wr", 64'(p0.wr), 64'(1));
      chk("stall_data", 64'(p0.wdata), 64'(hold_data));
    end
    tick();
    chk("right_after_release", 64'(p0.addr), 64'(A_RIGHT));
    chk("right_wr", 64'(p0.wr), 64'(1));
    for (int n = 0; n < 20 && m_sent == start; n++) tick();
    chk("stall_pair_done", 64'(m_sent), 64'(start + 1));
    chk("stall_word", 64'(last_r0), 64'(32'h1696_8000));

    // Reset while the RIGHTDATA write is on the bus.
    rst_on_r = 1'b1;
    src_q.push_back(18'h01234);
    for (int n = 0; n < 30 && !p_reset; n++) tick();
    chk("reset_armed", 64'(p_reset), 64'(1));
    tick();
    chk("mid_reset_sent", 64'(p0.sent), 64'(0));
    chk("mid_reset_strobes", 64'({p0.rd, p0.wr}), 64'(0));
    tick();
    chk("ready_after_mid_reset", 64'(p0.ready), 64'(1));

    // Random traffic, random wait states and random FIFOSPACE.
    acc0       = accepted;
    wait_rand  = 1'b1;
    space_rand = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (src_q.size() < 2 && $urandom_range(0, 1) == 1) src_q.push_back(18'($urandom));
      tick();
    end
    wait_rand  = 1'b0;
    space_rand = 1'b0;
    space_word = 32'h8080_0000;
    for (int n = 0; n < 400 && (src_q.size() + mq.size() + e0_addr.size()) > 0; n++) tick();
    chk("random_drained", 64'(src_q.size() + mq.size() + e0_addr.size() + e2_addr.size()), 64'(0));
    chk("random_pairs", 64'(m_sent), 64'(accepted - acc0));
    chk("random_sent_atten", 64'(sent2), 64'(m_sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
